// File: rtl/writeback_arbiter_if.sv
// Bundle between the result producers (ALU, load unit) and the write-back
// arbiter, together with the register-file write port and the status that
// hazard logic observes. The arbiter connects to the slave modport. The
// producer and register-file side connects to the master modport.
interface writeback_arbiter_if #(
    parameter int WORD_SIZE  = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 alu_valid;
    logic [4:0]           alu_rd;
    logic [WORD_SIZE-1:0] alu_data;
    logic                 alu_ready;
    logic                 mem_valid;
    logic [4:0]           mem_rd;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 mem_ready;
    logic                 wb_en;
    logic [4:0]           wb_rd;
    logic [WORD_SIZE-1:0] wb_data;
    logic [31:0]          pending;
    logic [CW-1:0]        fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready, wb_en, wb_rd, wb_data, pending, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready, wb_en, wb_rd, wb_data, pending, fifo_count
    );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU results and queued memory results into one
// register-file write per cycle.
// - ALU results win, except when the FIFO is full or when an older queued
//   write targets the same register. In that case the FIFO head drains first.
// - The write port outputs (wb_en, wb_rd, wb_data) are registered.
// - pending shows every destination that is still in flight.
// Optional feature: define WB_BYPASS_EN to let a lone memory result skip the
// empty FIFO and land in the write-back registers one cycle after acceptance.
module writeback_arbiter #(
    parameter int WORD_SIZE  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    writeback_arbiter_if.slave   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage is kept in flops because every entry feeds the hazard
    // compare and the pending mask.
    logic [4:0]           fifo_rd_q   [FIFO_DEPTH];
    logic [4:0]           fifo_rd_d   [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] fifo_data_q [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic                 wb_en_q, wb_en_d;
    logic [4:0]           wb_rd_q, wb_rd_d;
    logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;

    logic [FIFO_DEPTH-1:0] match;
    logic [31:0]          entry_mask [FIFO_DEPTH];
    logic                 full, empty, hazard, pop, push, alu_take, bypass;

    // Each queued entry contributes a hazard match and a pending bit.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        assign match[gi]      = vld_q[gi] && (fifo_rd_q[gi] == bus.alu_rd);
        assign entry_mask[gi] = vld_q[gi] ? (32'd1 << fifo_rd_q[gi]) : 32'd0;
    end

    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign hazard = bus.alu_valid && (|match);

`ifdef WB_BYPASS_EN
    assign bypass = empty && !bus.alu_valid && bus.mem_valid;
`else
    assign bypass = 1'b0;
`endif

    // The ALU is refused while the FIFO is full. It is also refused while an
    // older queued write targets the same rd, so that last-writer order holds.
    assign bus.alu_ready = !full && !(|match);
    assign bus.mem_ready = !full;
    assign alu_take      = bus.alu_valid && bus.alu_ready;
    assign pop           = !empty && (full || hazard || !bus.alu_valid);
    assign push          = bus.mem_valid && bus.mem_ready && !bypass;

    // FIFO next state: push at the tail, pop at the head, wrap the pointers.
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        vld_d       = vld_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = bus.mem_rd;
            fifo_data_d[wr_ptr_q] = bus.mem_data;
            vld_d[wr_ptr_q]       = 1'b1;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Slot selection: FIFO drain (full or hazard), then ALU, then bypass.
    // A write to x0 still consumes its slot but leaves wb_en low.
    always_comb begin
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (pop) begin
            wb_rd_d   = fifo_rd_q[rd_ptr_q];
            wb_data_d = fifo_data_q[rd_ptr_q];
            wb_en_d   = (fifo_rd_q[rd_ptr_q] != 5'd0);
        end else if (alu_take) begin
            wb_rd_d   = bus.alu_rd;
            wb_data_d = bus.alu_data;
            wb_en_d   = (bus.alu_rd != 5'd0);
        end else if (bypass) begin
            wb_rd_d   = bus.mem_rd;
            wb_data_d = bus.mem_data;
            wb_en_d   = (bus.mem_rd != 5'd0);
        end
    end

    // Control state and the write-back registers. Reset discards every queued result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= '0;
        end else begin
            vld_q     <= vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Entry payloads need no reset, because the valid bits qualify them.
    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    // Pending mask: queued destinations plus the live wb stage. x0 is never pending.
    always_comb begin
        bus.pending = wb_en_q ? (32'd1 << wb_rd_q) : 32'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            bus.pending = bus.pending | entry_mask[i];
        end
        bus.pending[0] = 1'b0;
    end

    assign bus.wb_en      = wb_en_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter.
// Each step queues the writes it expects, in the order the arbitration rules
// dictate. A negedge monitor pops and compares every register-file write.
module tb_writeback_arbiter;
    localparam int WS = 32;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.WORD_SIZE(WS), .FIFO_DEPTH(FD)) bus ();

    writeback_arbiter #(.WORD_SIZE(WS), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [36:0] exp_q [$];
    logic [36:0] mon_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        cyc();
    endtask

    // Scoreboard monitor: every write-back must match the next expected write.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("pending_bit0", 64'(bus.pending[0]), 64'd0);
            if (bus.wb_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_en", 64'(bus.wb_en), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("write rd=%0d data=%08h (expected rd=%0d data=%08h)",
                             bus.wb_rd, bus.wb_data, mon_e[36:32], mon_e[31:0]);
                    chk("wb_rd", 64'(bus.wb_rd), 64'(mon_e[36:32]));
                    chk("wb_data", 64'(bus.wb_data), 64'(mon_e[31:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_wb_en", 64'(bus.wb_en), 64'd0);
        chk("reset_fifo_count", 64'(bus.fifo_count), 64'd0);
        chk("reset_pending", 64'(bus.pending), 64'd0);
        chk("reset_mem_ready", 64'(bus.mem_ready), 64'd1);
        mon_en = 1'b1;
        cyc();

        // ALU only
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        #1 chk("alu_ready", 64'(bus.alu_ready), 64'd1);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        cyc();
        bus.alu_valid = 1'b0;
        #1;
        chk("alu_lat_wb_en", 64'(bus.wb_en), 64'd1);
        chk("alu_lat_wb_rd", 64'(bus.wb_rd), 64'd5);
        chk("alu_lat_wb_data", 64'(bus.wb_data), 64'hDEADBEEF);
        chk("alu_pending", 64'(bus.pending), 64'h20);
        drain();

        // Priority and fill: ALU every cycle, mem rd 10..13
        for (int k = 0; k < 4; k++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(k + 1); bus.alu_data = 32'(32'h100 + k + 1);
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(k + 10); bus.mem_data = 32'(32'h200 + k + 10);
            #1;
            chk("fill_alu_ready", 64'(bus.alu_ready), 64'd1);
            chk("fill_mem_ready", 64'(bus.mem_ready), 64'd1);
            exp_q.push_back({5'(k + 1), 32'(32'h100 + k + 1)});
            cyc();
        end
        bus.alu_rd = 5'd5; bus.alu_data = 32'h105; bus.mem_valid = 1'b0;
        #1;
        chk("full_count", 64'(bus.fifo_count), 64'd4);
        chk("full_mem_ready", 64'(bus.mem_ready), 64'd0);
        chk("full_alu_ready", 64'(bus.alu_ready), 64'd0);
        exp_q.push_back({5'd10, 32'h20A});
        cyc();
        #1;
        chk("after_full_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("after_full_count", 64'(bus.fifo_count), 64'd3);
        exp_q.push_back({5'd5, 32'h105});
        cyc();
        bus.alu_valid = 1'b0;
        exp_q.push_back({5'd11, 32'h20B});
        exp_q.push_back({5'd12, 32'h20C});
        exp_q.push_back({5'd13, 32'h20D});
        drain();
        chk("fill_final_count", 64'(bus.fifo_count), 64'd0);

        // Ordering hazard on rd=7
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'hA;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h11;
        #1 chk("hz_first_alu_ready", 64'(bus.alu_ready), 64'd1);
        exp_q.push_back({5'd20, 32'hA});
        cyc();
        bus.alu_rd = 5'd7; bus.alu_data = 32'h22; bus.mem_valid = 1'b0;
        #1;
        chk("hz_alu_ready", 64'(bus.alu_ready), 64'd0);
        chk("hz_pending7", 64'(bus.pending[7]), 64'd1);
        chk("hz_count", 64'(bus.fifo_count), 64'd1);
        exp_q.push_back({5'd7, 32'h11});
        cyc();
        #1 chk("hz_release_alu_ready", 64'(bus.alu_ready), 64'd1);
        exp_q.push_back({5'd7, 32'h22});
        cyc();
        bus.alu_valid = 1'b0;
        drain();

        // x0 writes from both sources
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h2;
        #1;
        chk("x0_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("x0_mem_ready", 64'(bus.mem_ready), 64'd1);
        cyc();
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        #1;
        chk("x0_wb_en_a", 64'(bus.wb_en), 64'd0);
        chk("x0_count_a", 64'(bus.fifo_count), 64'd1);
        chk("x0_pending_a", 64'(bus.pending), 64'd0);
        cyc();
        #1;
        chk("x0_wb_en_b", 64'(bus.wb_en), 64'd0);
        chk("x0_count_b", 64'(bus.fifo_count), 64'd0);
        drain();

        // Lone memory result into an empty FIFO
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h5;
        exp_q.push_back({5'd3, 32'h5});
        #1;
        cyc();
        bus.mem_valid = 1'b0;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_wb_en", 64'(bus.wb_en), 64'd1);
        chk("byp_wb_rd", 64'(bus.wb_rd), 64'd3);
        chk("byp_count", 64'(bus.fifo_count), 64'd0);
`else
        chk("mem_wb_en_early", 64'(bus.wb_en), 64'd0);
        chk("mem_count", 64'(bus.fifo_count), 64'd1);
        cyc();
        #1;
        chk("mem_wb_en", 64'(bus.wb_en), 64'd1);
        chk("mem_wb_rd", 64'(bus.wb_rd), 64'd3);
`endif
        drain();

        // Reset in the middle of traffic
        mon_en = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'h88;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
        cyc();
        bus.alu_rd = 5'd12; bus.mem_rd = 5'd10; bus.mem_data = 32'hAA;
        cyc();
        chk("pre_rst_count", 64'(bus.fifo_count), 64'd2);
        rst = 1'b1;
        #1;
        chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
        chk("rst_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_pending", 64'(bus.pending), 64'd0);
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        exp_q.delete();
        repeat (2) cyc();
        rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("post_rst_wb_en", 64'(bus.wb_en), 64'd0);
        end
        chk("post_rst_count", 64'(bus.fifo_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
